// File: rtl/vga_point_overlay.sv
// Double-buffered laser-spot list drawn as coloured squares over a VGA pixel stream.
// Two-stage pipeline: hit vector, then priority-encoded colour; syncs delayed to match.
`timescale 1ns/1ps
module vga_point_overlay #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned R     = 1,
  parameter logic [2:0]  BG    = 3'b000
) (
  input  logic                           vclock,
  input  logic                           reset_n,
  input  logic [9:0]                     hcount,
  input  logic [9:0]                     vcount,
  input  logic                           hsync,
  input  logic                           vsync,
  input  logic                           blank,
  input  logic [9:0]                     pt_x,
  input  logic [9:0]                     pt_y,
  input  logic [2:0]                     pt_color,
  input  logic                           pt_valid,
  output logic                           pt_ready,
  input  logic                           pt_commit,
  output logic                           commit_pending,
  output logic                           frame_swap,
  output logic [$clog2(DEPTH+1)-1:0]     front_count,
  output logic [2:0]                     rgb,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           blank_out
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic signed [10:0] R_POS = 11'(R);
  localparam logic signed [10:0] R_NEG = -R_POS;

  // Entry layout: {x[22:13], y[12:3], color[2:0]}
  logic [22:0]       bank_a [DEPTH];
  logic [22:0]       bank_b [DEPTH];
  logic              front;
  logic [CW-1:0]     back_count;
  logic              swapped_lo;
  logic              wr_en;
  logic              swap;

  logic [DEPTH-1:0]  hit_c;
  logic [DEPTH-1:0]  hit_q;
  logic              hs_q, vs_q, bl_q;
  logic [2:0]        hit_color;
  logic              hit_found;
  logic signed [10:0] dx, dy;
  logic [22:0]       ent;

  assign pt_ready = ~commit_pending & (back_count < CW'(DEPTH));
  assign wr_en    = pt_valid & pt_ready;
  // swapped_lo limits the swap to one per vsync-low period
  assign swap     = commit_pending & ~vsync & ~swapped_lo;

  always_ff @(posedge vclock) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (back_count == CW'(i)) begin
          if (front) bank_a[i] <= {pt_x, pt_y, pt_color};
          else       bank_b[i] <= {pt_x, pt_y, pt_color};
        end
      end
    end
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      front          <= 1'b0;
      front_count    <= '0;
      back_count     <= '0;
      commit_pending <= 1'b0;
      frame_swap     <= 1'b0;
      swapped_lo     <= 1'b0;
    end else begin
      frame_swap <= swap;
      if (vsync)     swapped_lo <= 1'b0;
      else if (swap) swapped_lo <= 1'b1;
      if (swap) begin
        front          <= ~front;
        front_count    <= back_count;
        back_count     <= '0;
        commit_pending <= 1'b0;
      end else begin
        if (wr_en)     back_count     <= back_count + 1'b1;
        if (pt_commit) commit_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    hit_c = '0;
    dx    = '0;
    dy    = '0;
    ent   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent = front ? bank_b[i] : bank_a[i];
      dx  = $signed({1'b0, hcount}) - $signed({1'b0, ent[22:13]});
      dy  = $signed({1'b0, vcount}) - $signed({1'b0, ent[12:3]});
      hit_c[i] = (CW'(i) < front_count) && (dx >= R_NEG) && (dx <= R_POS)
                 && (dy >= R_NEG) && (dy <= R_POS);
    end
  end

  always_comb begin
    hit_color = BG;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (hit_q[i] && !hit_found) begin
        hit_found = 1'b1;
        hit_color = front ? bank_b[i][2:0] : bank_a[i][2:0];
      end
    end
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      hit_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      bl_q      <= 1'b1;
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      hit_q     <= hit_c;
      hs_q      <= hsync;
      vs_q      <= vsync;
      bl_q      <= blank;
      rgb       <= bl_q ? 3'b000 : hit_color;
      hsync_out <= hs_q;
      vsync_out <= vs_q;
      blank_out <= bl_q;
    end
  end

endmodule

// File: tb/tb_vga_point_overlay.sv
// Directed bench for vga_point_overlay: reset, rendering, bank swap, edges, reset mid-commit.
`timescale 1ns/1ps
module tb_vga_point_overlay;

  logic       vclock = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] hcount = '0, vcount = '0;
  logic       hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
  logic [9:0] pt_x = '0, pt_y = '0;
  logic [2:0] pt_color = '0;
  logic       pt_valid = 1'b0, pt_commit = 1'b0;
  logic       pt_ready, commit_pending, frame_swap;
  logic [4:0] front_count;
  logic [2:0] rgb;
  logic       hsync_out, vsync_out, blank_out;

  int total = 0;
  int bad   = 0;

  vga_point_overlay #(.DEPTH(16), .R(1), .BG(3'b000)) dut (
    .vclock(vclock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .pt_x(pt_x), .pt_y(pt_y),
    .pt_color(pt_color), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_commit(pt_commit), .commit_pending(commit_pending), .frame_swap(frame_swap),
    .front_count(front_count), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .blank_out(blank_out)
  );

  always #5 vclock = ~vclock;

  task automatic tick;
    @(posedge vclock);
    #1;
  endtask

  task automatic drive_pix(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
    hsync  = 1'b1;
    vsync  = 1'b1;
    blank  = (h >= 640) || (v >= 480);
  endtask

  task automatic pix_out(input int h, input int v, output logic [2:0] c);
    drive_pix(h, v);
    tick;
    tick;
    c = rgb;
  endtask

  task automatic write_pt(input int x, input int y, input logic [2:0] c);
    int n;
    n = 0;
    while (!pt_ready && n < 20) begin
      tick;
      n++;
    end
    if (!pt_ready) begin
      total++; bad++;
      $display("FAIL write_wait pt_ready=%0b expected=1", pt_ready);
    end else begin
      pt_x = 10'(x); pt_y = 10'(y); pt_color = c; pt_valid = 1'b1;
      tick;
      pt_valid = 1'b0;
    end
  endtask

  task automatic commit;
    pt_commit = 1'b1;
    tick;
    pt_commit = 1'b0;
  endtask

  task automatic do_vsync(output int pulses);
    pulses = 0;
    vcount = 10'd490; hsync = 1'b1; vsync = 1'b0; blank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (frame_swap) pulses++;
    end
    vsync = 1'b1; vcount = 10'd492;
    tick;
    if (frame_swap) pulses++;
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hsync = i[0]; vsync = ~i[0]; blank = i[1];
      hcount = 10'(100 + i); vcount = 10'd50;
      tick;
    end
    total++; if (rgb !== 3'b000) begin bad++; $display("FAIL reset_rgb got=%0h expected=0", rgb); end
    total++; if (blank_out !== 1'b1) begin bad++; $display("FAIL reset_blank got=%0b expected=1", blank_out); end
    total++; if (hsync_out !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%0b expected=1", hsync_out); end
    total++; if (vsync_out !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%0b expected=1", vsync_out); end
    total++; if (front_count !== 5'd0) begin bad++; $display("FAIL reset_front_count got=%0d expected=0", front_count); end
    total++; if (pt_ready !== 1'b1) begin bad++; $display("FAIL reset_pt_ready got=%0b expected=1", pt_ready); end
    total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%0b expected=0", commit_pending); end
    total++; if (frame_swap !== 1'b0) begin bad++; $display("FAIL reset_frame_swap got=%0b expected=0", frame_swap); end
    reset_n = 1'b1;
    drive_pix(0, 0);
    tick;
  endtask

  task automatic test_single_point;
    logic [2:0] c, e;
    int p, hits;
    write_pt(100, 50, 3'b100);
    commit;
    total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL sp_pending got=%0b expected=1", commit_pending); end
    total++; if (pt_ready !== 1'b0) begin bad++; $display("FAIL sp_ready_pending got=%0b expected=0", pt_ready); end
    pix_out(100, 50, c);
    total++; if (c !== 3'b000) begin bad++; $display("FAIL sp_before_swap got=%0h expected=0", c); end
    do_vsync(p);
    total++; if (p !== 1) begin bad++; $display("FAIL sp_swap_pulses got=%0d expected=1", p); end
    total++; if (front_count !== 5'd1) begin bad++; $display("FAIL sp_front_count got=%0d expected=1", front_count); end
    total++; if (pt_ready !== 1'b1) begin bad++; $display("FAIL sp_ready_after got=%0b expected=1", pt_ready); end
    for (int f = 0; f < 2; f++) begin
      hits = 0;
      for (int v = 48; v <= 52; v++) begin
        for (int h = 97; h <= 103; h++) begin
          pix_out(h, v, c);
          e = (h >= 99 && h <= 101 && v >= 49 && v <= 51) ? 3'b100 : 3'b000;
          if (c == 3'b100) hits++;
          total++; if (c !== e) begin bad++; $display("FAIL sp_pixel(%0d,%0d) got=%0h expected=%0h", h, v, c, e); end
        end
      end
      total++; if (hits !== 9) begin bad++; $display("FAIL sp_hit_count frame%0d got=%0d expected=9", f, hits); end
      do_vsync(p);
      total++; if (p !== 0) begin bad++; $display("FAIL sp_idle_swap got=%0d expected=0", p); end
    end
    pix_out(98, 50, c);
    drive_pix(100, 50);
    tick;
    total++; if (rgb !== 3'b000) begin bad++; $display("FAIL sp_lag1 got=%0h expected=0", rgb); end
    tick;
    total++; if (rgb !== 3'b100) begin bad++; $display("FAIL sp_lag2 got=%0h expected=4", rgb); end
    hsync = 1'b0; vsync = 1'b0; blank = 1'b1;
    tick;
    total++; if ({hsync_out, vsync_out, blank_out} !== 3'b110) begin bad++; $display("FAIL sync_lag1 got=%b expected=110", {hsync_out, vsync_out, blank_out}); end
    tick;
    total++; if ({hsync_out, vsync_out, blank_out} !== 3'b001) begin bad++; $display("FAIL sync_lag2 got=%b expected=001", {hsync_out, vsync_out, blank_out}); end
    total++; if (rgb !== 3'b000) begin bad++; $display("FAIL blank_rgb got=%0h expected=0", rgb); end
  endtask

  task automatic test_full_bank;
    logic [2:0] c;
    int p;
    for (int i = 0; i < 16; i++) write_pt(200 + 10 * i, 300, 3'((i % 7) + 1));
    total++; if (pt_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b expected=0", pt_ready); end
    pt_x = 10'd600; pt_y = 10'd10; pt_color = 3'b111; pt_valid = 1'b1;
    tick;
    pt_valid = 1'b0;
    total++; if (pt_ready !== 1'b0) begin bad++; $display("FAIL full_17th_ready got=%0b expected=0", pt_ready); end
    commit;
    do_vsync(p);
    total++; if (p !== 1) begin bad++; $display("FAIL full_swap got=%0d expected=1", p); end
    total++; if (front_count !== 5'd16) begin bad++; $display("FAIL full_front_count got=%0d expected=16", front_count); end
    total++; if (pt_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%0b expected=1", pt_ready); end
    pix_out(200, 300, c);
    total++; if (c !== 3'd1) begin bad++; $display("FAIL full_pt0 got=%0h expected=1", c); end
    pix_out(351, 301, c);
    total++; if (c !== 3'd2) begin bad++; $display("FAIL full_pt15 got=%0h expected=2", c); end
    pix_out(600, 10, c);
    total++; if (c !== 3'd0) begin bad++; $display("FAIL full_17th_drawn got=%0h expected=0", c); end
    pix_out(100, 50, c);
    total++; if (c !== 3'd0) begin bad++; $display("FAIL full_old_list got=%0h expected=0", c); end
  endtask

  task automatic test_commit_timing;
    logic [2:0] c;
    write_pt(320, 1, 3'b011);
    drive_pix(0, 200);
    commit;
    total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL ct_pending got=%0b expected=1", commit_pending); end
    total++; if (pt_ready !== 1'b0) begin bad++; $display("FAIL ct_ready got=%0b expected=0", pt_ready); end
    pix_out(200, 300, c);
    total++; if (c !== 3'd1) begin bad++; $display("FAIL ct_old_list got=%0h expected=1", c); end
    pix_out(320, 1, c);
    total++; if (c !== 3'd0) begin bad++; $display("FAIL ct_new_early got=%0h expected=0", c); end
    vcount = 10'd489; vsync = 1'b1; blank = 1'b1;
    tick; tick;
    total++; if ({frame_swap, commit_pending} !== 2'b01) begin bad++; $display("FAIL ct_pre_vsync got=%b expected=01", {frame_swap, commit_pending}); end
    vcount = 10'd490; vsync = 1'b0;
    tick;
    total++; if ({frame_swap, commit_pending} !== 2'b10) begin bad++; $display("FAIL ct_swap_edge got=%b expected=10", {frame_swap, commit_pending}); end
    total++; if (front_count !== 5'd1) begin bad++; $display("FAIL ct_front_count got=%0d expected=1", front_count); end
    tick;
    total++; if (frame_swap !== 1'b0) begin bad++; $display("FAIL ct_pulse_width got=%0b expected=0", frame_swap); end
    vcount = 10'd492; vsync = 1'b1;
    tick;
    pix_out(320, 0, c);
    total++; if (c !== 3'b011) begin bad++; $display("FAIL ct_line0 got=%0h expected=3", c); end
    pix_out(200, 300, c);
    total++; if (c !== 3'd0) begin bad++; $display("FAIL ct_old_gone got=%0h expected=0", c); end
  endtask

  task automatic test_overlap_edges;
    int hx [12] = '{1, 0, 2, 638, 639, 638, 639, 637, 639, 0, 639, 640};
    int vy [12] = '{0, 0, 0, 478, 478, 479, 479, 479, 477, 479, 0, 479};
    logic [2:0] ex [12] = '{3'b001, 3'b001, 3'b010, 3'b111, 3'b111, 3'b111, 3'b111,
                            3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] c;
    int p;
    write_pt(0, 0, 3'b001);
    write_pt(1, 0, 3'b010);
    write_pt(639, 479, 3'b111);
    commit;
    do_vsync(p);
    total++; if (p !== 1) begin bad++; $display("FAIL oe_swap got=%0d expected=1", p); end
    total++; if (front_count !== 5'd3) begin bad++; $display("FAIL oe_front_count got=%0d expected=3", front_count); end
    for (int k = 0; k < 12; k++) begin
      pix_out(hx[k], vy[k], c);
      total++; if (c !== ex[k]) begin bad++; $display("FAIL oe_pixel(%0d,%0d) got=%0h expected=%0h", hx[k], vy[k], c, ex[k]); end
    end
  endtask

  task automatic test_reset_pending;
    logic [2:0] c;
    int p;
    write_pt(400, 400, 3'b101);
    write_pt(410, 400, 3'b110);
    write_pt(420, 400, 3'b011);
    commit;
    total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL rp_pending got=%0b expected=1", commit_pending); end
    #3 reset_n = 1'b0;
    #1;
    total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL rp_async_pending got=%0b expected=0", commit_pending); end
    total++; if (front_count !== 5'd0) begin bad++; $display("FAIL rp_async_count got=%0d expected=0", front_count); end
    total++; if (pt_ready !== 1'b1) begin bad++; $display("FAIL rp_async_ready got=%0b expected=1", pt_ready); end
    total++; if (rgb !== 3'b000) begin bad++; $display("FAIL rp_async_rgb got=%0h expected=0", rgb); end
    tick;
    reset_n = 1'b1;
    do_vsync(p);
    total++; if (p !== 0) begin bad++; $display("FAIL rp_no_swap got=%0d expected=0", p); end
    total++; if (front_count !== 5'd0) begin bad++; $display("FAIL rp_front_count got=%0d expected=0", front_count); end
    pix_out(1, 0, c);
    total++; if (c !== 3'd0) begin bad++; $display("FAIL rp_empty got=%0h expected=0", c); end
    write_pt(50, 60, 3'b101);
    commit;
    do_vsync(p);
    total++; if (front_count !== 5'd1) begin bad++; $display("FAIL rp_back_count_cleared got=%0d expected=1", front_count); end
    pix_out(50, 60, c);
    total++; if (c !== 3'b101) begin bad++; $display("FAIL rp_new_point got=%0h expected=5", c); end
    pix_out(410, 400, c);
    total++; if (c !== 3'd0) begin bad++; $display("FAIL rp_stale_point got=%0h expected=0", c); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_point;
    test_full_bank;
    test_commit_timing;
    test_overlap_edges;
    test_reset_pending;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
